// File: rtl/inst_dispatch.sv
// Two-lane in-order instruction dispatcher with a register scoreboard.
// Lane 1 always holds the older instruction; lane 2 may only issue once lane 1 is clear.
module inst_dispatch #(
  parameter int INS_PART_WID = 4,
  parameter int NUM_REGS     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    inst_1_fetch,
  output logic                    inst_2_fetch,
  input  logic                    inst_1_valid,
  input  logic                    inst_2_valid,
  input  logic [INS_PART_WID-1:0] inst_1_type,
  input  logic [INS_PART_WID-1:0] inst_1_dest,
  input  logic [INS_PART_WID-1:0] inst_1_src0,
  input  logic [INS_PART_WID-1:0] inst_1_src1,
  input  logic [INS_PART_WID-1:0] inst_2_type,
  input  logic [INS_PART_WID-1:0] inst_2_dest,
  input  logic [INS_PART_WID-1:0] inst_2_src0,
  input  logic [INS_PART_WID-1:0] inst_2_src1,
  output logic                    iss_1_valid,
  output logic                    iss_2_valid,
  input  logic                    iss_1_ready,
  input  logic                    iss_2_ready,
  output logic [INS_PART_WID-1:0] iss_1_type,
  output logic [INS_PART_WID-1:0] iss_1_dest,
  output logic [INS_PART_WID-1:0] iss_1_src0,
  output logic [INS_PART_WID-1:0] iss_1_src1,
  output logic [INS_PART_WID-1:0] iss_2_type,
  output logic [INS_PART_WID-1:0] iss_2_dest,
  output logic [INS_PART_WID-1:0] iss_2_src0,
  output logic [INS_PART_WID-1:0] iss_2_src1,
  input  logic                    wb_1_valid,
  input  logic                    wb_2_valid,
  input  logic [INS_PART_WID-1:0] wb_1_dest,
  input  logic [INS_PART_WID-1:0] wb_2_dest,
  output logic [NUM_REGS-1:0]     sb_busy,
  output logic [15:0]             issue_cnt,
  output logic [15:0]             stall_cnt
);

  localparam logic [INS_PART_WID-1:0] TYPE_NOP = {INS_PART_WID{1'b0}};
  localparam logic [NUM_REGS-1:0]     ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic                    hold_1_r, hold_2_r;
  logic [INS_PART_WID-1:0] type_1_r, dest_1_r, src0_1_r, src1_1_r;
  logic [INS_PART_WID-1:0] type_2_r, dest_2_r, src0_2_r, src1_2_r;

  logic live_1_s, live_2_s, nop_1_s, nop_2_s;
  logic haz_1_s, haz_2_s, intra_s, xfer_1_s, xfer_2_s, stall_s;
  logic [NUM_REGS-1:0] set_s, clr_s;
  logic [15:0]         issue_add_s;

  // Hazard evaluation, issue handshake and scoreboard update masks
  always_comb begin
    live_1_s = hold_1_r && (type_1_r != TYPE_NOP);
    live_2_s = hold_2_r && (type_2_r != TYPE_NOP);
    nop_1_s  = hold_1_r && (type_1_r == TYPE_NOP);
    nop_2_s  = hold_2_r && (type_2_r == TYPE_NOP);
    haz_1_s  = sb_busy[src0_1_r] || sb_busy[src1_1_r] || sb_busy[dest_1_r];
    haz_2_s  = sb_busy[src0_2_r] || sb_busy[src1_2_r] || sb_busy[dest_2_r];

    iss_1_valid  = live_1_s && !haz_1_s;
    xfer_1_s     = iss_1_valid && iss_1_ready;
    inst_1_fetch = !hold_1_r || nop_1_s || xfer_1_s;

    // Lane 2 sees lane 1's destination as busy when both would go together
    intra_s = xfer_1_s && ((dest_1_r == src0_2_r) || (dest_1_r == src1_2_r) ||
                           (dest_1_r == dest_2_r));
    iss_2_valid  = live_2_s && !haz_2_s && inst_1_fetch && !intra_s;
    xfer_2_s     = iss_2_valid && iss_2_ready;
    inst_2_fetch = !hold_2_r || nop_2_s || xfer_2_s;

    set_s = ((xfer_1_s ? ONE_HOT0 : {NUM_REGS{1'b0}}) << dest_1_r) |
            ((xfer_2_s ? ONE_HOT0 : {NUM_REGS{1'b0}}) << dest_2_r);
    clr_s = ((wb_1_valid ? ONE_HOT0 : {NUM_REGS{1'b0}}) << wb_1_dest) |
            ((wb_2_valid ? ONE_HOT0 : {NUM_REGS{1'b0}}) << wb_2_dest);

    issue_add_s = {15'd0, xfer_1_s} + {15'd0, xfer_2_s};
    stall_s     = (live_1_s && !xfer_1_s) || (live_2_s && !xfer_2_s);
  end

  // Issue fields are driven only while the lane offers an instruction
  always_comb begin
    iss_1_type = iss_1_valid ? type_1_r : TYPE_NOP;
    iss_1_dest = iss_1_valid ? dest_1_r : TYPE_NOP;
    iss_1_src0 = iss_1_valid ? src0_1_r : TYPE_NOP;
    iss_1_src1 = iss_1_valid ? src1_1_r : TYPE_NOP;
    iss_2_type = iss_2_valid ? type_2_r : TYPE_NOP;
    iss_2_dest = iss_2_valid ? dest_2_r : TYPE_NOP;
    iss_2_src0 = iss_2_valid ? src0_2_r : TYPE_NOP;
    iss_2_src1 = iss_2_valid ? src1_2_r : TYPE_NOP;
  end

  // Lane 1 holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_1_r <= 1'b0;
      type_1_r <= TYPE_NOP;
      dest_1_r <= TYPE_NOP;
      src0_1_r <= TYPE_NOP;
      src1_1_r <= TYPE_NOP;
    end else if (inst_1_fetch && inst_1_valid) begin
      hold_1_r <= 1'b1;
      type_1_r <= inst_1_type;
      dest_1_r <= inst_1_dest;
      src0_1_r <= inst_1_src0;
      src1_1_r <= inst_1_src1;
    end else if (inst_1_fetch) begin
      hold_1_r <= 1'b0;
    end else begin
      hold_1_r <= hold_1_r;
    end
  end

  // Lane 2 holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_2_r <= 1'b0;
      type_2_r <= TYPE_NOP;
      dest_2_r <= TYPE_NOP;
      src0_2_r <= TYPE_NOP;
      src1_2_r <= TYPE_NOP;
    end else if (inst_2_fetch && inst_2_valid) begin
      hold_2_r <= 1'b1;
      type_2_r <= inst_2_type;
      dest_2_r <= inst_2_dest;
      src0_2_r <= inst_2_src0;
      src1_2_r <= inst_2_src1;
    end else if (inst_2_fetch) begin
      hold_2_r <= 1'b0;
    end else begin
      hold_2_r <= hold_2_r;
    end
  end

  // Scoreboard: issue-set takes priority over a same-cycle writeback clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy <= {NUM_REGS{1'b0}};
    end else begin
      sb_busy <= (sb_busy & ~clr_s) | set_s;
    end
  end

  // Issue and stall counters, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      issue_cnt <= issue_cnt + issue_add_s;
      stall_cnt <= stall_cnt + {15'd0, stall_s};
    end
  end

endmodule
